gbsha_fir_mac: RTL and testbench

Parametrised, time-multiplexed FIR filter: the next-generation filter core for the tile's io pins. It has N_TAPS runtime-loadable signed coefficients, a single shared multiplier iterated over the taps, and a valid/ready sample handshake. Output is rounded and saturated to BW_out bits. It sits between the input sample pins and the output pins, with the coefficient port driven from the configuration pins.

---
 rtl/gbsha_fir_pkg.sv | 29 ++
 rtl/gbsha_fir_requant.sv | 50 +++++
 rtl/gbsha_fir_mac.sv | 155 +++++++++++++++
 tb/tb_gbsha_fir_mac.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbsha_fir_pkg.sv
// Shared definitions for the gbsha FIR MAC core.
//   state_e     : controller states (IDLE, MAC, DONE)
//   bw_acc      : accumulator width, wide enough that summing N_TAPS
//                 full-scale products can never overflow
//   addr_width  : coefficient address width (at least one bit)
//   h_rst       : coefficient value restored by reset for tap k
package gbsha_fir_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int bw_acc(input int bw_in, input int bw_coef, input int n_taps);
      return bw_in + bw_coef + $clog2(n_taps);
   endfunction

   function automatic int addr_width(input int n_taps);
      return (n_taps > 1) ? $clog2(n_taps) : 1;
   endfunction

   function automatic int h_rst(input int k);
      if (k == 0) return 1;
      if (k == 1) return 2;
      return 0;
   endfunction

endpackage

// File: rtl/gbsha_fir_requant.sv
// Combinational requantiser: arithmetic right shift by OUT_SHIFT with
// round-half-up, then saturation to a signed BW_OUT-bit result.
//   acc_i : signed accumulator, BW_ACC bits
//   y_o   : signed saturated result, BW_OUT bits
module gbsha_fir_requant #(
   parameter int BW_ACC    = 18,
   parameter int BW_OUT    = 8,
   parameter int OUT_SHIFT = 0
)(
   input  logic [BW_ACC-1:0] acc_i,
   output logic [BW_OUT-1:0] y_o
);

   // One guard bit so adding the rounding constant can never wrap.
   localparam int BW_EXT = BW_ACC + 1;

   logic signed [BW_EXT-1:0] acc_ext;
   logic signed [BW_EXT-1:0] shifted;

   assign acc_ext = BW_EXT'($signed(acc_i));

   if (OUT_SHIFT > 0) begin : g_round
      localparam logic signed [BW_EXT-1:0] HALF = BW_EXT'(1) << (OUT_SHIFT - 1);
      logic signed [BW_EXT-1:0] rounded;
      assign rounded = acc_ext + HALF;
      assign shifted = rounded >>> OUT_SHIFT;
   end else begin : g_noround
      assign shifted = acc_ext;
   end

   if (BW_OUT >= BW_EXT) begin : g_nosat
      assign y_o = BW_OUT'(shifted);
   end else begin : g_sat
      // The value fits when every bit from the output sign bit upward
      // agrees; otherwise clamp towards the sign of the shifted value.
      localparam int NTOP = BW_EXT - BW_OUT + 1;
      logic [NTOP-1:0] top_bits;
      assign top_bits = shifted[BW_EXT-1:BW_OUT-1];
      always_comb begin
         if ((top_bits == '0) || (top_bits == '1)) begin
            y_o = shifted[BW_OUT-1:0];
         end else if (shifted[BW_EXT-1]) begin
            y_o = {1'b1, {(BW_OUT-1){1'b0}}};
         end else begin
            y_o = {1'b0, {(BW_OUT-1){1'b1}}};
         end
      end
   end

endmodule

// File: rtl/gbsha_fir_mac.sv
// Time-multiplexed FIR filter with one shared multiplier.
// A sample accepted in IDLE is shifted into the delay line, then MAC
// spends N_TAPS cycles accumulating h[k]*x_dl[k], and DONE registers the
// requantised sum into y_out with a one-cycle y_valid pulse.
//   clk       : clock, rising edge
//   reset     : asynchronous reset, active low
//   x_in      : signed input sample (BW_in)
//   x_valid   : sample offered
//   x_ready   : core idle and able to accept a sample
//   coef_we   : coefficient write strobe (honoured in IDLE only)
//   coef_addr : tap index for the write
//   coef_data : signed coefficient (BW_coef)
//   y_out     : signed filtered output (BW_out), held between results
//   y_valid   : one-cycle pulse when y_out updates
module gbsha_fir_mac
   import gbsha_fir_pkg::*;
#(
   parameter int N_TAPS    = 4,
   parameter int BW_in     = 8,
   parameter int BW_coef   = 8,
   parameter int BW_out    = 8,
   parameter int OUT_SHIFT = 0,
   localparam int BW_ACC   = bw_acc(BW_in, BW_coef, N_TAPS),
   localparam int AW       = addr_width(N_TAPS)
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [BW_in-1:0]   x_in,
   input  logic               x_valid,
   output logic               x_ready,
   input  logic               coef_we,
   input  logic [AW-1:0]      coef_addr,
   input  logic [BW_coef-1:0] coef_data,
   output logic [BW_out-1:0]  y_out,
   output logic               y_valid
);

   localparam int BW_P = BW_in + BW_coef;

   state_e state_q, state_d;

   logic signed [BW_in-1:0]   x_dl_q [N_TAPS];
   logic signed [BW_coef-1:0] h_q    [N_TAPS];
   logic signed [BW_ACC-1:0]  acc_q, acc_d;
   logic [AW-1:0]             k_q, k_d;
   logic [BW_out-1:0]         y_out_q, y_out_d;
   logic                      y_valid_q, y_valid_d;

   logic                      accept;
   logic                      coef_wr;
   logic                      last_tap;
   logic signed [BW_P-1:0]    prod;
   logic signed [BW_ACC-1:0]  prod_ext;
   logic [BW_out-1:0]         y_req;

   assign x_ready  = (state_q == IDLE);
   assign accept   = x_ready && x_valid;
   assign coef_wr  = x_ready && coef_we && (int'(coef_addr) < N_TAPS);
   assign last_tap = (k_q == AW'(N_TAPS - 1));

   // Shared multiplier, operand selected by the tap counter.
   assign prod     = BW_P'(h_q[k_q]) * BW_P'(x_dl_q[k_q]);
   assign prod_ext = BW_ACC'(prod);

   for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_tap
      // A write in the accept cycle lands before MAC reads the bank,
      // so that sample already sees the new coefficient.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            h_q[gi] <= BW_coef'(h_rst(gi));
         end else if (coef_wr && (coef_addr == AW'(gi))) begin
            h_q[gi] <= coef_data;
         end
      end

      if (gi == 0) begin : g_head
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               x_dl_q[gi] <= '0;
            end else if (accept) begin
               x_dl_q[gi] <= x_in;
            end
         end
      end else begin : g_body
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               x_dl_q[gi] <= '0;
            end else if (accept) begin
               x_dl_q[gi] <= x_dl_q[gi-1];
            end
         end
      end
   end

   gbsha_fir_requant #(
      .BW_ACC    (BW_ACC),
      .BW_OUT    (BW_out),
      .OUT_SHIFT (OUT_SHIFT)
   ) u_requant (
      .acc_i (acc_q),
      .y_o   (y_req)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         k_q       <= '0;
         y_out_q   <= '0;
         y_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         k_q       <= k_d;
         y_out_q   <= y_out_d;
         y_valid_q <= y_valid_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      k_d       = k_q;
      y_out_d   = y_out_q;
      y_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (x_valid) begin
               state_d = MAC;
               acc_d   = '0;
               k_d     = '0;
            end
         end
         MAC: begin
            acc_d = acc_q + prod_ext;
            k_d   = k_q + AW'(1);
            if (last_tap) begin
               state_d = DONE;
            end
         end
         DONE: begin
            y_out_d   = y_req;
            y_valid_d = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign y_out   = y_out_q;
   assign y_valid = y_valid_q;

endmodule

// File: tb/tb_gbsha_fir_mac.sv
// Scoreboard bench for gbsha_fir_mac. Two instances share one stimulus:
// dut_a (BW_out=16, no shift) and dut_b (BW_out=8, OUT_SHIFT=2).
// A reference model computes each filter result from the tap sums and
// queues it; a monitor on the falling edge pops and compares results,
// latency, output hold and x_ready.
module tb_gbsha_fir_mac;

   localparam int NT  = 4;
   localparam int LAT = NT + 1;

   typedef struct {
      int ya;
      int yb;
      int cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  x_in = '0;
   logic        x_valid = 1'b0;
   logic        coef_we = 1'b0;
   logic [1:0]  coef_addr = '0;
   logic [7:0]  coef_data = '0;
   logic        x_ready_a, x_ready_b, y_valid_a, y_valid_b;
   logic [15:0] y_out_a;
   logic [7:0]  y_out_b;

   gbsha_fir_mac #(.N_TAPS(NT), .BW_in(8), .BW_coef(8), .BW_out(16), .OUT_SHIFT(0)) dut_a (
      .clk(clk), .reset(rst_n), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready_a),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .y_out(y_out_a), .y_valid(y_valid_a));

   gbsha_fir_mac #(.N_TAPS(NT), .BW_in(8), .BW_coef(8), .BW_out(8), .OUT_SHIFT(2)) dut_b (
      .clk(clk), .reset(rst_n), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready_b),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .y_out(y_out_b), .y_valid(y_valid_b));

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int   h_m [NT];
   int   dl_m [NT];
   int   busy_m = 0;
   int   cyc = 0;
   bit   acc_edge = 0;
   exp_t exp_q [$];
   int   last_a = 0, last_b = 0;
   int   n_cmp = 0, n_bad = 0, n_txn = 0;

   function automatic int requant(input longint acc, input int sh, input int bw);
      longint r, d, hi, lo;
      r = acc;
      if (sh > 0) begin
         d = longint'(1) << sh;
         r = acc + d / 2;
         if (r >= 0) r = r / d;
         else        r = -((-r + d - 1) / d);
      end
      hi = (longint'(1) << (bw - 1)) - 1;
      lo = -(longint'(1) << (bw - 1));
      if (r > hi) r = hi;
      if (r < lo) r = lo;
      return int'(r);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NT; k++) begin
         dl_m[k] = 0;
         h_m[k]  = (k == 0) ? 1 : (k == 1) ? 2 : 0;
      end
      busy_m = 0;
      exp_q.delete();
      last_a = 0;
      last_b = 0;
   endtask

   always @(posedge clk) begin
      longint acc;
      exp_t e;
      cyc++;
      acc_edge = 0;
      if (rst_n) begin
         if (busy_m == 0) begin
            if (coef_we) h_m[coef_addr] = int'($signed(coef_data));
            if (x_valid) begin
               for (int k = NT - 1; k > 0; k--) dl_m[k] = dl_m[k-1];
               dl_m[0] = int'($signed(x_in));
               acc = 0;
               for (int k = 0; k < NT; k++) acc += longint'(h_m[k]) * longint'(dl_m[k]);
               e.ya  = requant(acc, 0, 16);
               e.yb  = requant(acc, 2, 8);
               e.cyc = cyc;
               exp_q.push_back(e);
               busy_m   = LAT;
               acc_edge = 1;
            end
         end else begin
            busy_m--;
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      exp_t e;
      bit rdy;
      if (rst_n) begin
         rdy = (busy_m == 0);
         n_cmp++;
         if (x_ready_a !== rdy || x_ready_b !== rdy) begin
            n_bad++;
            $display("FAIL x_ready cyc=%0d got a=%b b=%b want %b", cyc, x_ready_a, x_ready_b, rdy);
         end
         if (y_valid_a || y_valid_b) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL spurious_y_valid cyc=%0d got va=%b vb=%b want no output", cyc, y_valid_a, y_valid_b);
            end else begin
               e = exp_q.pop_front();
               n_txn++;
               if (!(y_valid_a && y_valid_b) || $signed(y_out_a) != e.ya || $signed(y_out_b) != e.yb
                   || (cyc - e.cyc) != LAT) begin
                  n_bad++;
                  $display("FAIL result txn=%0d got a=%0d b=%0d va=%b vb=%b lat=%0d want a=%0d b=%0d lat=%0d",
                           n_txn, $signed(y_out_a), $signed(y_out_b), y_valid_a, y_valid_b,
                           cyc - e.cyc, e.ya, e.yb, LAT);
               end else begin
                  $display("txn %0d: y_a=%0d y_b=%0d lat=%0d", n_txn, e.ya, e.yb, cyc - e.cyc);
               end
               last_a = e.ya;
               last_b = e.yb;
            end
         end else begin
            n_cmp++;
            if ($signed(y_out_a) != last_a || $signed(y_out_b) != last_b) begin
               n_bad++;
               $display("FAIL y_hold cyc=%0d got a=%0d b=%0d want a=%0d b=%0d",
                        cyc, $signed(y_out_a), $signed(y_out_b), last_a, last_b);
            end
            if (exp_q.size() != 0 && (cyc - exp_q[0].cyc) > LAT) begin
               e = exp_q.pop_front();
               n_cmp++;
               n_bad++;
               $display("FAIL timeout no y_valid for accept at cyc=%0d (now %0d) want a=%0d b=%0d",
                        e.cyc, cyc, e.ya, e.yb);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int g = 0; g < 20 && busy_m != 0; g++) tick();
   endtask

   task automatic send(input int x);
      wait_idle();
      x_valid = 1'b1;
      x_in    = 8'(x);
      tick();
      x_valid = 1'b0;
   endtask

   task automatic wcoef(input int a, input int d);
      wait_idle();
      coef_we   = 1'b1;
      coef_addr = 2'(a);
      coef_data = 8'(d);
      tick();
      coef_we   = 1'b0;
   endtask

   // x_valid held high throughout; with noise, coef_we toggles while busy.
   task automatic stream(input int v0, input int v1, input int v2, input int v3, input bit noise);
      int vals [4];
      int i = 0;
      vals = '{v0, v1, v2, v3};
      x_valid = 1'b1;
      for (int g = 0; g < 60 && i < 4; g++) begin
         x_in      = 8'(vals[i]);
         coef_we   = noise && (busy_m != 0) && ($urandom_range(0, 1) == 1);
         coef_addr = 2'($urandom_range(0, 3));
         coef_data = 8'($urandom_range(0, 255));
         tick();
         if (acc_edge) i++;
      end
      x_valid = 1'b0;
      coef_we = 1'b0;
   endtask

   task automatic drain();
      for (int g = 0; g < 30 && exp_q.size() != 0; g++) tick();
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      n_cmp++;
      if (y_out_a !== '0 || y_out_b !== '0 || y_valid_a !== 1'b0 || y_valid_b !== 1'b0
          || x_ready_a !== 1'b1 || x_ready_b !== 1'b1) begin
         n_bad++;
         $display("FAIL %s got ya=%0d yb=%0d va=%b vb=%b ra=%b rb=%b want 0 0 0 0 1 1", tag,
                  y_out_a, y_out_b, y_valid_a, y_valid_b, x_ready_a, x_ready_b);
      end
   endtask

   initial begin
      model_reset();
      #2;
      check_reset_outputs("reset_state");
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // reset coefficients 1, 2, 0, 0
      send(5); send(0); send(0);
      drain();

      // coefficient load then back-to-back samples
      wcoef(0, 3); wcoef(1, -1); wcoef(2, 2); wcoef(3, 1);
      stream(1, 2, 3, 4, 1'b0);
      drain();

      // coef_we during MAC/DONE must be dropped
      stream(-7, 11, 100, -128, 1'b1);
      drain();

      // saturation and rounding
      wcoef(0, 127); wcoef(1, 0); wcoef(2, 0); wcoef(3, 0);
      send(127); send(-128);
      wcoef(0, 1);
      send(6); send(-6);
      drain();

      // coefficient write coinciding with an accept
      wait_idle();
      coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'd9;
      x_valid = 1'b1; x_in = 8'd3;
      tick();
      coef_we = 1'b0; x_valid = 1'b0;
      drain();

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         x_valid   = ($urandom_range(0, 2) != 0);
         x_in      = 8'($urandom_range(0, 255));
         coef_we   = ($urandom_range(0, 3) == 0);
         coef_addr = 2'($urandom_range(0, 3));
         coef_data = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                 : 8'($urandom_range(0, 15) - 8);
         tick();
      end
      x_valid = 1'b0;
      coef_we = 1'b0;
      drain();

      // asynchronous reset in the middle of MAC
      send(50);
      tick();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reset_outputs("async_reset");
      tick();
      rst_n = 1'b1;
      tick();
      send(7);
      send(-3);
      drain();

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL leftover got %0d pending results want 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
